fp_mul_arbiter: RTL
===================

Name: fp_mul_arbiter

Overview:
- Shares one single-precision FP multiplier datapath (fp_X, fp_Y, r_mode in; fp_Z, ovrf, udrf out) between NREQ requesters using round-robin arbitration.
- Registers the granted operands into the multiplier and tracks each operation through the multiplier's fixed latency.
- Returns results, tagged with the requester ID, through a credit-protected response FIFO with valid/ready backpressure.
- Sits between the issue ports of the FP unit clients and the fp_mul datapath.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8. IDW = $clog2(NREQ) is a localparam.
- MUL_LAT, 0, register stages inside the multiplier; 0 means a combinational multiplier.
- RSP_DEPTH, 4, response FIFO entries; must be >= MUL_LAT+2 for one-per-cycle throughput.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit set per cycle.
- req_X  in  NREQ*32  operand X, slice i*32 +: 32 belongs to requester i.
- req_Y  in  NREQ*32  operand Y, same packing as req_X.
- req_rmode  in  NREQ*3  rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM).
- mul_X  out  32  registered operand X driven to the multiplier fp_X.
- mul_Y  out  32  registered operand Y driven to the multiplier fp_Y.
- mul_rmode  out  3  registered rounding mode driven to the multiplier r_mode.
- mul_Z  in  32  multiplier result fp_Z.
- mul_ovrf  in  1  multiplier overflow flag.
- mul_udrf  in  1  multiplier underflow flag.
- rsp_valid  out  1  response FIFO head valid.
- rsp_ready  in  1  consumer accepts the head entry.
- rsp_id  out  IDW  requester ID of the head entry.
- rsp_Z  out  32  result of the head entry.
- rsp_ovrf  out  1  overflow flag of the head entry.
- rsp_udrf  out  1  underflow flag of the head entry.

Behaviour:
- Reset:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_Z=0, rsp_ovrf=0, rsp_udrf=0.
  - mul_X=0, mul_Y=0, mul_rmode=0.
  - RR pointer=0, occupancy=0, tracker valid bits=0, FIFO empty.
  - Reset mid-operation discards all in-flight and queued results; nothing is emitted afterwards for them.
- Occupancy (occ): in-flight ops plus FIFO entries.
  - occ_next = occ + accept - (rsp_valid & rsp_ready).
  - Accept is permitted only when occ < RSP_DEPTH.
  - No same-cycle credit reuse: a pop does not enable an accept in the same cycle.
- Arbitration (combinational on req_valid, ptr, occ):
  - Grant goes to the first i with req_valid[i], scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[grant]=1 only if occ < RSP_DEPTH; all other bits are 0.
  - On accept, ptr <= grant+1 mod NREQ; otherwise ptr holds.
  - Requesters hold valid and data stable until ready; the arbiter never revokes a grant while valid is held and space exists.
- Issue:
  - On accept at edge k, mul_X, mul_Y, mul_rmode load the granted slices.
  - Tracker stage 0 loads {1, id}. Without an accept, stage 0 valid clears and mul_* hold their values.
- Tracking:
  - The tracker is a shift register of MUL_LAT+1 stages of {valid, id}, shifting every cycle (the multiplier never stalls).
  - When the last stage is valid, {id, mul_Z, mul_ovrf, mul_udrf} is pushed into the FIFO at that edge.
  - The accept at edge k is pushed at edge k+MUL_LAT+1; rsp_valid is high from that edge if the FIFO was empty.
- FIFO:
  - Registered outputs, first-word fall-through from the head.
  - Push and pop in the same cycle are legal, including when full.
  - The credit rule guarantees no push to a full FIFO.
  - Pointers wrap at RSP_DEPTH.
  - While rsp_valid=1 and rsp_ready=0, the head and all rsp_* outputs hold stable.
- Throughput: one accept per cycle sustained when RSP_DEPTH >= MUL_LAT+2 and rsp_ready=1.
- Ordering: responses leave in acceptance order.

Optional Feature:
- Macro: FP_MUL_ARB_STICKY_EN.
- When defined, the block adds:
  - Input sticky_clr (1 bit).
  - Output sticky_flags (NREQ*2), {ovrf, udrf} per requester.
- sticky_flags behaviour:
  - Each FIFO pop ORs the entry's rsp_ovrf and rsp_udrf into the bits of its rsp_id slot.
  - sticky_clr=1 clears all bits, with priority over a same-cycle set.
  - Reset value is 0.
- When the macro is undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single request: MUL_LAT=0, requester 1 sends 0x40400000 x 0x40400000 with rmode=001.
  - mul_X and mul_Y equal 0x40400000 after edge k.
  - rsp_valid at edge k+1 with rsp_id=1, rsp_Z=0x41100000, flags 0.
- Round-robin: all 4 requesters hold valid with rsp_ready=1.
  - Grants follow 0,1,2,3,0,... with one accept per cycle.
  - rsp_id sequence is 0,1,2,3.
- Backpressure: rsp_ready=0, requester 0 issues 0x3FC00000 x 0x40000000 repeatedly.
  - Exactly RSP_DEPTH=4 accepts occur, then req_ready stays 0.
  - The first response is 0x40400000 and holds stable.
  - Raising rsp_ready drains 4 entries in order, and accepts resume the cycle after the first pop.
- Pipeline latency: MUL_LAT=2 with a stub multiplier.
  - Result is captured at edge k+3.
  - Back-to-back accepts keep their order and IDs.
- Reset mid-flight: assert rst with 3 ops in flight and 2 in the FIFO.
  - All outputs go to reset values immediately.
  - No responses appear after release; ptr restarts at 0.
- Sticky flags (with FP_MUL_ARB_STICKY_EN):
  - A stub returns ovrf=1 for requester 2; after its pop, sticky_flags[5:4]=2'b10.
  - sticky_clr zeroes the bits on the next edge.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP multiplier between NREQ requesters, with an
// ID tracker and credit-protected response FIFO. Optional: FP_MUL_ARB_STICKY_EN.
module fp_mul_arbiter #(
    parameter int NREQ      = 4,
    parameter int MUL_LAT   = 0,
    parameter int RSP_DEPTH = 4,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_X,
    input  logic [NREQ*32-1:0]   req_Y,
    input  logic [NREQ*3-1:0]    req_rmode,
    output logic [31:0]          mul_X,
    output logic [31:0]          mul_Y,
    output logic [2:0]           mul_rmode,
    input  logic [31:0]          mul_Z,
    input  logic                 mul_ovrf,
    input  logic                 mul_udrf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_Z,
    output logic                 rsp_ovrf,
    output logic                 rsp_udrf
`ifdef FP_MUL_ARB_STICKY_EN
    ,
    input  logic                 sticky_clr,
    output logic [NREQ*2-1:0]    sticky_flags
`endif
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int OW = $clog2(RSP_DEPTH + 1);
    localparam int EW = IDW + 34;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    logic [IDW-1:0]           ptr;
    logic [IDW-1:0]           grant;
    logic [IDW:0]             cand;
    logic                     found;
    logic [OW-1:0]            occ;
    logic                     accept;
    logic                     pop;
    logic                     push;
    logic [MUL_LAT:0]         trk_v;
    logic [MUL_LAT:0][IDW-1:0] trk_id;

    logic [EW-1:0]            mem [RSP_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            rd_nxt;
    logic [OW-1:0]            cnt;
    logic [OW-1:0]            cnt_nxt;
    logic [EW-1:0]            push_data;
    logic [EW-1:0]            head_nxt;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                grant = cand[IDW-1:0];
            end
        end
        // Credits are counted before this cycle's pop, so a pop never frees a slot in the same cycle.
        accept = found && (occ < OW'(RSP_DEPTH)) && !rst;
        req_ready = '0;
        req_ready[grant] = accept;
    end

    assign pop       = rsp_valid & rsp_ready;
    assign push      = trk_v[MUL_LAT];
    assign push_data = {trk_id[MUL_LAT], mul_Z, mul_ovrf, mul_udrf};

    always_comb begin
        rd_nxt  = pop ? wrap_inc(rd_ptr) : rd_ptr;
        cnt_nxt = cnt + OW'(push) - OW'(pop);
        // If the only surviving entry is the one arriving now, bypass the array.
        head_nxt = (push && (cnt - OW'(pop)) == '0) ? push_data : mem[rd_nxt];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            occ       <= '0;
            trk_v     <= '0;
            trk_id    <= '0;
            mul_X     <= '0;
            mul_Y     <= '0;
            mul_rmode <= '0;
        end else begin
            occ      <= occ + OW'(accept) - OW'(pop);
            trk_v[0] <= accept;
            for (int s = 1; s <= MUL_LAT; s++) begin
                trk_v[s]  <= trk_v[s-1];
                trk_id[s] <= trk_id[s-1];
            end
            if (accept) begin
                ptr       <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                trk_id[0] <= grant;
                mul_X     <= req_X[32*grant +: 32];
                mul_Y     <= req_Y[32*grant +: 32];
                mul_rmode <= req_rmode[3*grant +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            {rsp_id, rsp_Z, rsp_ovrf, rsp_udrf} <= '0;
        end else begin
            if (push)
                wr_ptr <= wrap_inc(wr_ptr);
            rd_ptr    <= rd_nxt;
            cnt       <= cnt_nxt;
            rsp_valid <= (cnt_nxt != '0);
            if (cnt_nxt != '0 && (pop || !rsp_valid))
                {rsp_id, rsp_Z, rsp_ovrf, rsp_udrf} <= head_nxt;
        end
    end

`ifdef FP_MUL_ARB_STICKY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_flags <= '0;
        else if (sticky_clr)
            sticky_flags <= '0;
        else if (pop)
            sticky_flags[2*rsp_id +: 2] <= sticky_flags[2*rsp_id +: 2] | {rsp_ovrf, rsp_udrf};
    end
`endif

endmodule
